// File: rtl/init_pkg.sv
// init_pkg: shared types and constants for the power-on init sequencer.
`default_nettype none

package init_pkg;

    typedef struct packed {
        logic initialized;
        logic not_initialized;
    } init_status_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } seq_state_t;

    localparam init_status_t ST_INIT     = '{initialized: 1'b1, not_initialized: 1'b0};
    localparam init_status_t ST_NOT_INIT = '{initialized: 1'b0, not_initialized: 1'b1};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/init_timeout_cnt.sv
// init_timeout_cnt: counts stalled write cycles; expired flags the final allowed stall.
`default_nettype none

module init_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Combinational so the FSM can leave WRITE on the very cycle the limit is hit.
    assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/init_sequencer.sv
// init_sequencer: walks an (address, data) table on start and issues each entry as a valid/ready write.
`default_nettype none

module init_sequencer
    import init_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 15,
    parameter int IDX_W       = idx_width(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output init_status_t      status,
    output logic              busy,
    output logic              error,
    output logic [IDX_W-1:0]  err_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    seq_state_t        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    init_status_t      status_q;
    logic              busy_q;
    logic              error_q;
    logic [IDX_W-1:0]  err_idx_q;
    logic              expired;

    init_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == LOAD),
        .en      ((state_q == WRITE) && !wr_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            status_q  <= ST_NOT_INIT;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    addr_q  <= tbl_addr;
                    data_q  <= tbl_data;
                    valid_q <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    // A ready arriving on the expiry cycle is still a handshake.
                    if (wr_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= LOAD;
                        end
                    end else if (expired) begin
                        valid_q   <= 1'b0;
                        state_q   <= FAIL;
                        error_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        err_idx_q <= idx_q;
                    end
                end
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state_q  <= LOAD;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        error_q  <= 1'b0;
                        status_q <= ST_NOT_INIT;
                    end else if (state_q == DONE) begin
                        status_q <= ST_INIT;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tbl_idx  = idx_q;
    assign wr_valid = valid_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign status   = status_q;
    assign busy     = busy_q;
    assign error    = error_q;
    assign err_idx  = err_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_init_sequencer.sv
// tb_init_sequencer: directed scoreboard bench for init_sequencer (4 entries, TIMEOUT=15).
`default_nettype none

module tb_init_sequencer;
    import init_pkg::*;

    localparam int N     = 4;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int TO    = 15;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] tbl_idx;
    logic [AW-1:0] tbl_addr;
    logic [DW-1:0] tbl_data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready = 1'b1;
    init_status_t  status;
    logic          busy;
    logic          error;
    logic [IW-1:0] err_idx;

    logic [AW-1:0] t_addr [N] = '{8'h10, 8'h14, 8'h18, 8'h1C};
    logic [DW-1:0] t_data [N] = '{32'hA, 32'hB, 32'hC, 32'hD};

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs_base;
    logic [AW+DW-1:0] sb_q [$];

    assign tbl_addr = t_addr[tbl_idx];
    assign tbl_data = t_data[tbl_idx];

    always #5 clk = ~clk;

    init_sequencer #(
        .NUM_ENTRIES (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT     (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tbl_idx  (tbl_idx),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .status   (status),
        .busy     (busy),
        .error    (error),
        .err_idx  (err_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_entries(input int count);
        for (int i = 0; i < count; i++) sb_q.push_back({t_addr[i], t_data[i]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick(1);
            n++;
        end
        check("wait_done_busy", 64'(busy), 64'(0));
    endtask

    // Handshakes are observed mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        check("status_onehot", 64'($countones(status)), 64'(1));
        if (!rst && wr_valid && wr_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'(1), 64'(0));
            end else begin
                check("write_addr_data", 64'({wr_addr, wr_data}), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        tick(2);
        rst = 1'b0;
        check("rst_valid",   64'(wr_valid), 64'(0));
        check("rst_busy",    64'(busy),     64'(0));
        check("rst_error",   64'(error),    64'(0));
        check("rst_status",  64'(status),   64'(ST_NOT_INIT));
        check("rst_idx",     64'(tbl_idx),  64'(0));
        check("rst_erridx",  64'(err_idx),  64'(0));
        check("rst_addr",    64'(wr_addr),  64'(0));
        check("rst_data",    64'(wr_data),  64'(0));

        // Full sequence with ready tied high: valid on alternate cycles
        push_entries(N);
        pulse_start();
        check("t1_busy", 64'(busy), 64'(1));
        for (int k = 1; k <= 2 * N; k++) begin
            tick(1);
            check("t1_valid_cadence", 64'(wr_valid), 64'(k % 2));
        end
        check("t1_status_pre", 64'(status), 64'(ST_NOT_INIT));
        tick(1);
        check("t1_status_init", 64'(status), 64'(ST_INIT));
        check("t1_busy_done",   64'(busy),   64'(0));
        check("t1_hs",          64'(hs_cnt), 64'(4));
        check("t1_sb_empty",    64'(sb_q.size()), 64'(0));

        // Restart from DONE; stall entry 2 for three cycles
        push_entries(N);
        pulse_start();
        check("t2_restart_status", 64'(status), 64'(ST_NOT_INIT));
        check("t2_restart_busy",   64'(busy),   64'(1));
        tick(4);
        wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t2_hold_valid", 64'(wr_valid), 64'(1));
            check("t2_hold_addr",  64'(wr_addr),  64'(8'h18));
            check("t2_hold_data",  64'(wr_data),  64'(32'hC));
        end
        wr_ready = 1'b1;
        wait_done(50);
        check("t2_error",  64'(error),  64'(0));
        check("t2_status", 64'(status), 64'(ST_INIT));
        check("t2_hs",     64'(hs_cnt), 64'(8));

        // Ready stuck low: valid held TIMEOUT cycles, then abort
        wr_ready = 1'b0;
        pulse_start();
        for (int k = 1; k <= TO; k++) begin
            tick(1);
            check("t3_valid_wait", 64'(wr_valid), 64'(1));
        end
        tick(1);
        check("t3_valid_drop", 64'(wr_valid), 64'(0));
        tick(1);
        check("t3_error",  64'(error),   64'(1));
        check("t3_erridx", 64'(err_idx), 64'(0));
        check("t3_status", 64'(status),  64'(ST_NOT_INIT));
        check("t3_busy",   64'(busy),    64'(0));
        check("t3_hs",     64'(hs_cnt),  64'(8));

        // Ready arrives exactly on the final allowed cycle
        push_entries(N);
        pulse_start();
        check("t4_error_cleared", 64'(error), 64'(0));
        tick(TO);
        check("t4_valid_last", 64'(wr_valid), 64'(1));
        wr_ready = 1'b1;
        wait_done(50);
        check("t4_error",  64'(error),  64'(0));
        check("t4_status", 64'(status), 64'(ST_INIT));
        check("t4_hs",     64'(hs_cnt), 64'(12));

        // Reset during entry 1 write, then rewrite from entry 0
        push_entries(1);
        pulse_start();
        tick(3);
        check("t5_pre_valid", 64'(wr_valid), 64'(1));
        check("t5_pre_addr",  64'(wr_addr),  64'(8'h14));
        wr_ready = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_valid",  64'(wr_valid), 64'(0));
        check("t5_rst_busy",   64'(busy),     64'(0));
        check("t5_rst_status", 64'(status),   64'(ST_NOT_INIT));
        tick(2);
        check("t5_idle_valid", 64'(wr_valid), 64'(0));
        check("t5_sb_empty",   64'(sb_q.size()), 64'(0));
        wr_ready = 1'b1;
        push_entries(N);
        pulse_start();
        wait_done(50);
        check("t5_status", 64'(status), 64'(ST_INIT));
        check("t5_hs",     64'(hs_cnt), 64'(17));

        // start while busy is ignored
        hs_base = hs_cnt;
        push_entries(N);
        pulse_start();
        tick(2);
        pulse_start();
        tick(1);
        pulse_start();
        wait_done(50);
        tick(4);
        check("t6_single_seq", 64'(hs_cnt - hs_base), 64'(4));
        check("t6_idle_valid", 64'(wr_valid), 64'(0));
        check("t6_status",     64'(status),   64'(ST_INIT));
        check("t6_sb_empty",   64'(sb_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
